// File: rtl/mem_arbiter.sv
// Single memory port shared by the CPU and a DMA requester with CPU priority.
// Optional CPU bus lock is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  cpu_lock,
`endif
  input  logic                  dma_req,
  input  logic                  dma_wr,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_e;

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_STATES);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic                    own_dma_q, own_dma_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   crd_q, crd_d;
  logic [DATA_WIDTH-1:0]   drd_q, drd_d;
  logic                    lock_hold;
  logic                    dma_win;
  logic                    cpu_win;

`ifdef MEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  assign lock_hold = lock_q & cpu_req;
`else
  assign lock_hold = 1'b0;
`endif

  // DMA wins when the CPU is idle or has starved it long enough
  assign dma_win = dma_req & ~lock_hold &
                   (~cpu_req | (starve_q == S_MAX));
  assign cpu_win = cpu_req & ~dma_win;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = crd_q;
  assign dma_rdata = drd_q;

  // Next-state, datapath latching and strobe/ack decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    own_dma_d = own_dma_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    crd_d     = crd_q;
    drd_d     = drd_q;
`ifdef MEM_ARB_LOCK_EN
    lock_d    = lock_q;
`endif
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    cpu_ack   = 1'b0;
    dma_ack   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dma_win || cpu_win) begin
          state_d   = S_ACCESS;
          cnt_d     = CNT_INIT;
          own_dma_d = dma_win;
          wr_d      = dma_win ? dma_wr : cpu_wr;
          addr_d    = dma_win ? dma_addr : cpu_addr;
          wdata_d   = dma_win ? dma_wdata : cpu_wdata;
        end
        if (!dma_req || dma_win) begin
          starve_d = '0;
        end else if (cpu_win && starve_q != S_MAX) begin
          starve_d = starve_q + 1'b1;
        end
`ifdef MEM_ARB_LOCK_EN
        if (!cpu_req) begin
          lock_d = 1'b0;
        end
`endif
      end
      S_ACCESS: begin
        mem_rd = ~wr_q;
        mem_wr = wr_q;
        if (cnt_q == '0) begin
          state_d = S_ACK;
          if (!wr_q) begin
            if (own_dma_q) begin
              drd_d = mem_rdata;
            end else begin
              crd_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK: begin
        cpu_ack = ~own_dma_q;
        dma_ack = own_dma_q;
        state_d = S_IDLE;
`ifdef MEM_ARB_LOCK_EN
        if (!own_dma_q) begin
          lock_d = cpu_lock;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      starve_q  <= '0;
      own_dma_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      crd_q     <= '0;
      drd_q     <= '0;
`ifdef MEM_ARB_LOCK_EN
      lock_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      own_dma_q <= own_dma_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      crd_q     <= crd_d;
      drd_q     <= drd_d;
`ifdef MEM_ARB_LOCK_EN
      lock_q    <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_STATES=1, STARVE_LIMIT=2).
// Expectation for the lock step follows MEM_ARB_LOCK_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, dma_req, dma_wr;
  logic [15:0] cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, mem_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_rdata;
  logic        cpu_ack, dma_ack, mem_rd, mem_wr;
`ifdef MEM_ARB_LOCK_EN
  logic        cpu_lock;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .WAIT_STATES(1),
    .STARVE_LIMIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack),
`ifdef MEM_ARB_LOCK_EN
    .cpu_lock(cpu_lock),
`endif
    .dma_req(dma_req),
    .dma_wr(dma_wr),
    .dma_addr(dma_addr),
    .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata),
    .dma_ack(dma_ack),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("rdwr_excl", 32'(mem_rd & mem_wr), 32'd0);
    chk("ack_excl", 32'(cpu_ack & dma_ack), 32'd0);
  endtask

  task automatic grant(input string tag,
                       input bit is_dma,
                       input logic [15:0] a);
    step();
    chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_rd1"}, 32'(mem_rd), 32'd1);
    step();
    chk({tag, "_rd2"}, 32'(mem_rd), 32'd1);
    step();
    chk({tag, "_cack"}, 32'(cpu_ack), 32'(!is_dma));
    chk({tag, "_dack"}, 32'(dma_ack), 32'(is_dma));
    step();
  endtask

  initial begin
    rst = 1'b0;
    cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;
`ifdef MEM_ARB_LOCK_EN
    cpu_lock = 1'b0;
`endif
    step();
    step();
    chk("rst_rd", 32'(mem_rd), 32'd0);
    chk("rst_wr", 32'(mem_wr), 32'd0);
    chk("rst_cack", 32'(cpu_ack), 32'd0);
    chk("rst_dack", 32'(dma_ack), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_crd", cpu_rdata, 32'd0);
    chk("rst_drd", dma_rdata, 32'd0);
    rst = 1'b1;
    step();

    // 1: CPU read
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0010;
    mem_rdata = 32'hDEADBEEF;
    step();
    chk("t1_rd_a", 32'(mem_rd), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'h10);
    chk("t1_ack_a", 32'(cpu_ack), 32'd0);
    step();
    chk("t1_rd_b", 32'(mem_rd), 32'd1);
    chk("t1_dack_b", 32'(dma_ack), 32'd0);
    step();
    chk("t1_cack", 32'(cpu_ack), 32'd1);
    chk("t1_rd_c", 32'(mem_rd), 32'd0);
    chk("t1_crd", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dack", 32'(dma_ack), 32'd0);
    cpu_req = 0;
    step();
    chk("t1_cack_off", 32'(cpu_ack), 32'd0);

    // 2: DMA write
    dma_req = 1; dma_wr = 1; dma_addr = 16'h0020;
    dma_wdata = 32'h12345678;
    step();
    chk("t2_wr_a", 32'(mem_wr), 32'd1);
    chk("t2_rd_a", 32'(mem_rd), 32'd0);
    chk("t2_addr", 32'(mem_addr), 32'h20);
    chk("t2_wdata", mem_wdata, 32'h12345678);
    step();
    chk("t2_wr_b", 32'(mem_wr), 32'd1);
    step();
    chk("t2_dack", 32'(dma_ack), 32'd1);
    chk("t2_cack", 32'(cpu_ack), 32'd0);
    chk("t2_wr_c", 32'(mem_wr), 32'd0);
    chk("t2_drd", dma_rdata, 32'd0);
    dma_req = 0; dma_wr = 0;
    step();

    // 3: simultaneous requests, CPU first then DMA four cycles later
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0030;
    dma_req = 1; dma_wr = 0; dma_addr = 16'h0040;
    mem_rdata = 32'hCAFEF00D;
    step();
    chk("t3_addr_c", 32'(mem_addr), 32'h30);
    step();
    step();
    chk("t3_cack", 32'(cpu_ack), 32'd1);
    chk("t3_crd", cpu_rdata, 32'hCAFEF00D);
    cpu_req = 0;
    mem_rdata = 32'h0BADF00D;
    step();
    chk("t3_idle", 32'(dma_ack | mem_rd), 32'd0);
    step();
    chk("t3_addr_d", 32'(mem_addr), 32'h40);
    step();
    step();
    chk("t3_dack", 32'(dma_ack), 32'd1);
    chk("t3_drd", dma_rdata, 32'h0BADF00D);
    chk("t3_crd_keep", cpu_rdata, 32'hCAFEF00D);
    dma_req = 0;
    step();

    // 4: both held, starvation guard interleaves DMA
    cpu_req = 1; cpu_addr = 16'h0050;
    dma_req = 1; dma_addr = 16'h0060;
    grant("t4_g1", 1'b0, 16'h0050);
    grant("t4_g2", 1'b0, 16'h0050);
    grant("t4_g3", 1'b1, 16'h0060);
    grant("t4_g4", 1'b0, 16'h0050);
    grant("t4_g5", 1'b0, 16'h0050);
    grant("t4_g6", 1'b1, 16'h0060);
    cpu_req = 0; dma_req = 0;
    step();

    // 5: reset during second access cycle abandons the access
    cpu_req = 1; cpu_addr = 16'h0070;
    mem_rdata = 32'h11112222;
    step();
    chk("t5_rd_a", 32'(mem_rd), 32'd1);
    step();
    chk("t5_rd_b", 32'(mem_rd), 32'd1);
    rst = 1'b0;
    step();
    chk("t5_rst_rd", 32'(mem_rd), 32'd0);
    chk("t5_rst_ack", 32'(cpu_ack), 32'd0);
    chk("t5_rst_addr", 32'(mem_addr), 32'd0);
    chk("t5_rst_crd", cpu_rdata, 32'd0);
    rst = 1'b1;
    step();
    chk("t5_re_addr", 32'(mem_addr), 32'h70);
    chk("t5_re_rd1", 32'(mem_rd), 32'd1);
    step();
    chk("t5_re_rd2", 32'(mem_rd), 32'd1);
    step();
    chk("t5_re_ack", 32'(cpu_ack), 32'd1);
    chk("t5_re_crd", cpu_rdata, 32'h11112222);
    cpu_req = 0;
    step();

    // 6: lock holds the bus for the CPU past the starve limit
`ifdef MEM_ARB_LOCK_EN
    cpu_lock = 1'b1;
`endif
    cpu_req = 1; cpu_addr = 16'h0080;
    dma_req = 1; dma_addr = 16'h0090;
    grant("t6_g1", 1'b0, 16'h0080);
    grant("t6_g2", 1'b0, 16'h0080);
`ifdef MEM_ARB_LOCK_EN
    grant("t6_g3", 1'b0, 16'h0080);
`else
    grant("t6_g3", 1'b1, 16'h0090);
`endif
    cpu_req = 0; dma_req = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
